// File: rtl/cpu_bus_pkg.sv
// Shared CPU bus definitions: access size codes, master ids and the request payload.
package cpu_bus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;

  typedef struct packed {
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/arb_order_fifo.sv
// Order FIFO of master ids for accepted-but-not-completed slave transactions.
module arb_order_fifo #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          push_id,
  input  logic          pop,
  output logic          head_id,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             push_ok_c;
  logic             pop_ok_c;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign count   = wr_ptr_q - rd_ptr_q;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (count == CW'(DEPTH));
  assign head_id = mem_q[rd_ptr_q[AW-1:0]];

  assign push_ok_c = push & ~full;
  assign pop_ok_c  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok_c) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_id;
      wr_ptr_d                = wr_ptr_q + CW'(1);
    end
    if (pop_ok_c) begin
      rd_ptr_d = rd_ptr_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Two-master (inst fetch / data) arbiter onto one SRAM-like slave port, with
// request locking, round-robin or fixed priority, and in-order data_ok routing.
module sram_like_arbiter
  import cpu_bus_pkg::*;
#(
  parameter  int unsigned MAX_OUT = 4,
  parameter  bit          RR      = 1'b1,
  localparam int unsigned CNT_W   = $clog2(MAX_OUT) + 1
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [1:0]        m0_size,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_addr_ok,
  output logic              m0_data_ok,
  output logic [DATA_W-1:0] m0_rdata,

  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [1:0]        m1_size,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_addr_ok,
  output logic              m1_data_ok,
  output logic [DATA_W-1:0] m1_rdata,

  output logic              s_req,
  output logic              s_wr,
  output logic [1:0]        s_size,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic              s_addr_ok,
  input  logic              s_data_ok,
  input  logic [DATA_W-1:0] s_rdata,

  output logic [CNT_W-1:0]  outstanding
);

  localparam logic [0:0] ST_OPEN   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0] state_q, state_d;
  logic       lock_id_q, lock_id_d;
  logic       rr_last_q, rr_last_d;

  logic       grant_c;
  logic       grant_req_c;
  logic       accept_c;
  logic       pop_c;
  logic       fifo_head;
  logic       fifo_empty;
  logic       fifo_full;
  bus_req_t   m0_bus, m1_bus, sel_bus;

  assign m0_bus = '{wr: m0_wr, size: m0_size, addr: m0_addr, wdata: m0_wdata};
  assign m1_bus = '{wr: m1_wr, size: m1_size, addr: m1_addr, wdata: m1_wdata};

  // Grant: a locked request keeps the port; otherwise sole requester, then RR or data-first.
  always_comb begin
    grant_c = ID_INST;
    if (state_q == ST_LOCKED) begin
      grant_c = lock_id_q;
    end else if (m0_req && !m1_req) begin
      grant_c = ID_INST;
    end else if (m1_req && !m0_req) begin
      grant_c = ID_DATA;
    end else if (m0_req && m1_req) begin
      grant_c = RR ? ~rr_last_q : ID_DATA;
    end
  end

  assign grant_req_c = (grant_c == ID_DATA) ? m1_req : m0_req;
  assign sel_bus     = (grant_c == ID_DATA) ? m1_bus : m0_bus;

  assign s_req    = grant_req_c & ~fifo_full & ~rst;
  assign s_wr     = sel_bus.wr;
  assign s_size   = sel_bus.size;
  assign s_addr   = sel_bus.addr;
  assign s_wdata  = sel_bus.wdata;
  assign accept_c = s_req & s_addr_ok;

  assign m0_addr_ok = accept_c & (grant_c == ID_INST);
  assign m1_addr_ok = accept_c & (grant_c == ID_DATA);

  // Lock FSM: a presented-but-unaccepted request pins the slave fields until accepted.
  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    rr_last_d = rr_last_q;
    case (state_q)
      ST_OPEN: begin
        if (s_req && !s_addr_ok) begin
          state_d   = ST_LOCKED;
          lock_id_d = grant_c;
        end
      end
      ST_LOCKED: begin
        if (accept_c) begin
          state_d = ST_OPEN;
        end
      end
      default: state_d = ST_OPEN;
    endcase
    if (accept_c) begin
      rr_last_d = grant_c;
    end
  end

  // rr_last resets to the data master so the instruction master is favoured first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_OPEN;
      lock_id_q <= ID_INST;
      rr_last_q <= ID_DATA;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      rr_last_q <= rr_last_d;
    end
  end

  // A data_ok with nothing in flight is a slave violation and is dropped.
  assign pop_c = s_data_ok & ~fifo_empty & ~rst;

  arb_order_fifo #(
    .DEPTH (MAX_OUT)
  ) u_order_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (accept_c),
    .push_id (grant_c),
    .pop     (pop_c),
    .head_id (fifo_head),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (outstanding)
  );

  assign m0_data_ok = pop_c & (fifo_head == ID_INST);
  assign m1_data_ok = pop_c & (fifo_head == ID_DATA);
  assign m0_rdata   = s_rdata;
  assign m1_rdata   = s_rdata;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench: a round-robin and a fixed-priority arbiter share one stimulus stream.
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        rst;

  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [1:0]  m0_size, m1_size;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        s_addr_ok, s_data_ok;
  logic [31:0] s_rdata;

  logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req, s_wr;
  logic [1:0]  s_size;
  logic [31:0] s_addr, s_wdata;
  logic [2:0]  outstanding;

  logic        f_m0_addr_ok, f_m0_data_ok, f_m1_addr_ok, f_m1_data_ok;
  logic [31:0] f_m0_rdata, f_m1_rdata;
  logic        f_s_req, f_s_wr;
  logic [1:0]  f_s_size;
  logic [31:0] f_s_addr, f_s_wdata;
  logic [2:0]  f_outstanding;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sram_like_arbiter #(.MAX_OUT(4), .RR(1'b1)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_addr_ok(m0_addr_ok), .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_addr_ok(m1_addr_ok), .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .outstanding(outstanding)
  );

  sram_like_arbiter #(.MAX_OUT(4), .RR(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_addr_ok(f_m0_addr_ok), .m0_data_ok(f_m0_data_ok), .m0_rdata(f_m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_addr_ok(f_m1_addr_ok), .m1_data_ok(f_m1_data_ok), .m1_rdata(f_m1_rdata),
    .s_req(f_s_req), .s_wr(f_s_wr), .s_size(f_s_size), .s_addr(f_s_addr), .s_wdata(f_s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .outstanding(f_outstanding)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 1'b1; m0_wr = 1'b0; m0_size = 2'd2; m0_addr = 32'h0; m0_wdata = 32'h0;
    m1_req = 1'b1; m1_wr = 1'b0; m1_size = 2'd2; m1_addr = 32'h0; m1_wdata = 32'h0;
    s_addr_ok = 1'b1; s_data_ok = 1'b1; s_rdata = 32'h0;

    // Reset held with both masters requesting.
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_s_req", s_req, 0);
      chk("rst_m0_aok", m0_addr_ok, 0);
      chk("rst_m1_aok", m1_addr_ok, 0);
      chk("rst_m0_dok", m0_data_ok, 0);
      chk("rst_m1_dok", m1_data_ok, 0);
      chk("rst_occ", outstanding, 0);
      chk("rst_fp_s_req", f_s_req, 0);
      tick();
    end
    rst = 1'b0;

    // Both request, slave always ready: RR alternates m0,m1; fixed priority picks m1.
    m0_addr = 32'h0000_1000; m1_addr = 32'h0000_2000;
    for (int k = 0; k < 4; k++) begin
      s_data_ok = (k > 0);
      #1;
      chk("rr_m0_aok", m0_addr_ok, (k % 2 == 0));
      chk("rr_m1_aok", m1_addr_ok, (k % 2 == 1));
      chk("rr_s_addr", s_addr, (k % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000);
      chk("rr_m0_dok", m0_data_ok, (k > 0) && ((k - 1) % 2 == 0));
      chk("rr_occ", outstanding, (k > 0));
      chk("fp_m1_aok", f_m1_addr_ok, 1);
      chk("fp_m0_aok", f_m0_addr_ok, 0);
      chk("fp_s_addr", f_s_addr, 32'h0000_2000);
      chk("fp_m1_dok", f_m1_data_ok, (k > 0));
      tick();
    end
    m0_req = 1'b0; m1_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b1;
    #1;
    chk("rr_drain_m1_dok", m1_data_ok, 1);
    chk("rr_drain_m0_dok", m0_data_ok, 0);
    tick();
    s_data_ok = 1'b0;
    #1;
    chk("rr_drain_occ", outstanding, 0);
    chk("fp_drain_occ", f_outstanding, 0);
    tick();

    // Single m0 read with immediate accept and next-cycle completion.
    m0_req = 1'b1; m0_addr = 32'hBFC0_0000; s_addr_ok = 1'b1;
    #1;
    chk("rd_s_req", s_req, 1);
    chk("rd_s_addr", s_addr, 32'hBFC0_0000);
    chk("rd_s_wr", s_wr, 0);
    chk("rd_m0_aok", m0_addr_ok, 1);
    chk("rd_m1_aok", m1_addr_ok, 0);
    tick();
    m0_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b1; s_rdata = 32'h1234_5678;
    #1;
    chk("rd_occ1", outstanding, 1);
    chk("rd_m0_dok", m0_data_ok, 1);
    chk("rd_m0_rdata", m0_rdata, 32'h1234_5678);
    chk("rd_m1_dok", m1_data_ok, 0);
    tick();
    s_data_ok = 1'b0;
    #1;
    chk("rd_occ0", outstanding, 0);
    tick();

    // m0 stalled by slave for 3 cycles while m1 arrives: fields stay on m0.
    m0_req = 1'b1; m0_addr = 32'h1000_0000; s_addr_ok = 1'b0;
    #1;
    chk("lk_s_req", s_req, 1);
    chk("lk_s_addr0", s_addr, 32'h1000_0000);
    chk("lk_m0_aok0", m0_addr_ok, 0);
    tick();
    m1_req = 1'b1; m1_addr = 32'h2000_0000; m1_wr = 1'b1; m1_size = 2'd2; m1_wdata = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lk_s_addr", s_addr, 32'h1000_0000);
      chk("lk_s_wr", s_wr, 0);
      chk("lk_m1_aok", m1_addr_ok, 0);
      chk("lk_fp_s_addr", f_s_addr, 32'h1000_0000);
      tick();
    end
    s_addr_ok = 1'b1;
    #1;
    chk("lk_acc_m0_aok", m0_addr_ok, 1);
    chk("lk_acc_m1_aok", m1_addr_ok, 0);
    chk("lk_acc_fp_m0_aok", f_m0_addr_ok, 1);
    tick();
    m0_req = 1'b0;
    #1;
    chk("wr_m1_aok", m1_addr_ok, 1);
    chk("wr_s_addr", s_addr, 32'h2000_0000);
    chk("wr_s_wr", s_wr, 1);
    chk("wr_s_size", s_size, 2);
    chk("wr_s_wdata", s_wdata, 32'hCAFE_F00D);
    chk("wr_occ", outstanding, 1);
    tick();
    m1_req = 1'b0; m1_wr = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b1; s_rdata = 32'hAAAA_5555;
    #1;
    chk("lk_occ2", outstanding, 2);
    chk("lk_m0_dok", m0_data_ok, 1);
    chk("lk_m1_dok0", m1_data_ok, 0);
    chk("lk_m0_rdata", m0_rdata, 32'hAAAA_5555);
    tick();
    #1;
    chk("lk_m1_dok", m1_data_ok, 1);
    chk("lk_m0_dok1", m0_data_ok, 0);
    chk("lk_occ1", outstanding, 1);
    tick();
    s_data_ok = 1'b0;
    #1;
    chk("lk_occ0", outstanding, 0);
    tick();

    // Fill to MAX_OUT issuing m1,m0,m1,m0 with completions withheld.
    s_addr_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      m1_req = (k % 2 == 0);
      m0_req = (k % 2 == 1);
      #1;
      chk("fill_m1_aok", m1_addr_ok, (k % 2 == 0));
      chk("fill_m0_aok", m0_addr_ok, (k % 2 == 1));
      chk("fill_occ", outstanding, k);
      tick();
    end
    m0_req = 1'b1; m1_req = 1'b1;
    #1;
    chk("full_occ", outstanding, 4);
    chk("full_s_req", s_req, 0);
    chk("full_m0_aok", m0_addr_ok, 0);
    chk("full_m1_aok", m1_addr_ok, 0);
    tick();
    s_data_ok = 1'b1;
    #1;
    chk("full_pop_m1_dok", m1_data_ok, 1);
    chk("full_pop_m0_dok", m0_data_ok, 0);
    chk("full_nobypass", s_req, 0);
    tick();
    s_data_ok = 1'b0;
    #1;
    chk("refill_occ", outstanding, 3);
    chk("refill_s_req", s_req, 1);
    chk("refill_m1_aok", m1_addr_ok, 1);
    chk("refill_fp_m1_aok", f_m1_addr_ok, 1);
    tick();
    m0_req = 1'b0; m1_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("ord_m0_dok", m0_data_ok, (k % 2 == 0));
      chk("ord_m1_dok", m1_data_ok, (k % 2 == 1));
      chk("ord_occ", outstanding, 4 - k);
      tick();
    end

    // Spurious data_ok on an empty FIFO is ignored.
    #1;
    chk("sp_m0_dok", m0_data_ok, 0);
    chk("sp_m1_dok", m1_data_ok, 0);
    chk("sp_occ", outstanding, 0);
    tick();
    s_data_ok = 1'b0;
    #1;
    chk("sp_occ_after", outstanding, 0);
    tick();

    // Reset with a transaction in flight discards it.
    m0_req = 1'b1; s_addr_ok = 1'b1;
    #1;
    chk("mid_m0_aok", m0_addr_ok, 1);
    tick();
    m0_req = 1'b0; s_addr_ok = 1'b0;
    #1;
    chk("mid_occ1", outstanding, 1);
    tick();
    rst = 1'b1; s_data_ok = 1'b1; m1_req = 1'b1; s_addr_ok = 1'b1;
    #1;
    chk("mid_rst_m0_dok", m0_data_ok, 0);
    chk("mid_rst_s_req", s_req, 0);
    chk("mid_rst_m1_aok", m1_addr_ok, 0);
    tick();
    rst = 1'b0; m1_req = 1'b0; s_addr_ok = 1'b0;
    #1;
    chk("mid_post_occ", outstanding, 0);
    chk("mid_post_m0_dok", m0_data_ok, 0);
    chk("mid_post_fp_occ", f_outstanding, 0);
    tick();
    s_data_ok = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
